// File: rtl/parking_spot_allocator.sv
// Parking lot occupancy keeper: grants the lowest free spot on entry, releases the
// named spot on exit, and drives a timed gate-open pulse after every granted transaction.
module parking_spot_allocator #(
    parameter int N_SPOTS     = 4,
    parameter int GATE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         entry_req,
    output logic                         entry_ack,
    output logic                         entry_nak,
    output logic [$clog2(N_SPOTS)-1:0]   entry_spot,
    input  logic                         exit_req,
    input  logic [$clog2(N_SPOTS)-1:0]   exit_spot,
    output logic                         exit_ack,
    output logic                         exit_err,
    output logic                         gate_open,
    output logic [N_SPOTS-1:0]           occ_map,
    output logic [$clog2(N_SPOTS+1)-1:0] free_cnt,
    output logic                         full
);

    localparam int SW = $clog2(N_SPOTS);
    localparam int CW = $clog2(N_SPOTS + 1);
    localparam int GW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        GATE = 2'd2
    } state_t;

    state_t              state;
    logic                granted;
    logic [GW-1:0]       gate_cnt;

    logic [N_SPOTS-1:0]  exit_sel;
    logic [N_SPOTS-1:0]  free_sel;
    logic [N_SPOTS:0]    lower_full;
    logic                exit_valid;
    logic [SW-1:0]       free_idx;

    // exit_sel is all-zero for an out-of-range exit_spot, which makes the exit invalid
    assign lower_full[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < N_SPOTS; gi++) begin : g_decode
            assign exit_sel[gi]     = (exit_spot == SW'(gi));
            assign free_sel[gi]     = ~occ_map[gi] & lower_full[gi];
            assign lower_full[gi+1] = lower_full[gi] & occ_map[gi];
        end
    endgenerate

    assign exit_valid = |(exit_sel & occ_map);

    always_comb begin
        free_idx = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (free_sel[i]) begin
                free_idx = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            granted    <= 1'b0;
            gate_cnt   <= '0;
            gate_open  <= 1'b0;
            entry_ack  <= 1'b0;
            entry_nak  <= 1'b0;
            exit_ack   <= 1'b0;
            exit_err   <= 1'b0;
            entry_spot <= '0;
            occ_map    <= '0;
            free_cnt   <= CW'(N_SPOTS);
            full       <= 1'b0;
        end else begin
            entry_ack <= 1'b0;
            entry_nak <= 1'b0;
            exit_ack  <= 1'b0;
            exit_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // exit wins a tie so a spot is freed before a possible entry
                    if (exit_req) begin
                        if (exit_valid) begin
                            occ_map  <= occ_map & ~exit_sel;
                            free_cnt <= free_cnt + CW'(1);
                            full     <= 1'b0;
                            exit_ack <= 1'b1;
                            granted  <= 1'b1;
                        end else begin
                            exit_err <= 1'b1;
                            granted  <= 1'b0;
                        end
                        state <= RESP;
                    end else if (entry_req) begin
                        if (!full) begin
                            occ_map    <= occ_map | free_sel;
                            free_cnt   <= free_cnt - CW'(1);
                            full       <= (free_cnt == CW'(1));
                            entry_spot <= free_idx;
                            entry_ack  <= 1'b1;
                            granted    <= 1'b1;
                        end else begin
                            entry_nak <= 1'b1;
                            granted   <= 1'b0;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (granted) begin
                        gate_open <= 1'b1;
                        gate_cnt  <= GW'(GATE_CYCLES);
                        state     <= GATE;
                    end else begin
                        state <= IDLE;
                    end
                end
                GATE: begin
                    if (gate_cnt == GW'(1)) begin
                        gate_open <= 1'b0;
                        gate_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        gate_cnt <= gate_cnt - GW'(1);
                    end
                end
                default: begin
                    gate_open <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Bench for parking_spot_allocator: directed scenarios then random gate traffic,
// checked against an array-based model of the lot.
module tb_parking_spot_allocator;

    localparam int N = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_spot = 2'd0;
    logic       entry_ack, entry_nak, exit_ack, exit_err, gate_open, full;
    logic [1:0] entry_spot;
    logic [N-1:0] occ_map;
    logic [2:0] free_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit model_occ [N];
    int last_spot = 0;

    parking_spot_allocator #(.N_SPOTS(N), .GATE_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .entry_req(entry_req), .entry_ack(entry_ack), .entry_nak(entry_nak),
        .entry_spot(entry_spot),
        .exit_req(exit_req), .exit_spot(exit_spot),
        .exit_ack(exit_ack), .exit_err(exit_err),
        .gate_open(gate_open), .occ_map(occ_map), .free_cnt(free_cnt), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_free();
        int f = 0;
        for (int i = 0; i < N; i++) f += model_occ[i] ? 0 : 1;
        return f;
    endfunction

    function automatic logic [31:0] model_map();
        logic [31:0] m = 0;
        for (int i = 0; i < N; i++) if (model_occ[i]) m = m + (32'd1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_occ[i] = 1'b0;
        last_spot = 0;
    endtask

    task automatic check_lot(input string tag);
        chk({tag, ".occ_map"}, 32'(occ_map), model_map());
        chk({tag, ".free_cnt"}, 32'(free_cnt), model_free());
        chk({tag, ".full"}, 32'(full), (model_free() == 0) ? 1 : 0);
    endtask

    // Drives the requested pair and serves them to completion, exit first if both.
    task automatic run_txn(input bit want_entry, input bit want_exit, input logic [1:0] spot);
        int  waited;
        int  glen;
        int  s;
        bit  exp_grant;
        bit  valid;
        entry_req = want_entry;
        exit_req  = want_exit;
        exit_spot = spot;
        while (entry_req || exit_req) begin
            waited = 0;
            do begin
                step();
                waited++;
            end while (!(entry_ack || entry_nak || exit_ack || exit_err) && waited < 30);
            chk("resp_in_time", (waited < 30) ? 1 : 0, 1);
            if (exit_req) begin
                valid = model_occ[spot];
                if (valid) model_occ[spot] = 1'b0;
                exp_grant = valid;
                chk("exit_ack", 32'(exit_ack), valid ? 1 : 0);
                chk("exit_err", 32'(exit_err), valid ? 0 : 1);
                chk("entry_pulses_on_exit", 32'({entry_ack, entry_nak}), 0);
                $display("txn exit spot=%0d ack=%0b err=%0b occ=%b free=%0d",
                         spot, exit_ack, exit_err, occ_map, free_cnt);
                exit_req = 1'b0;
            end else begin
                exp_grant = (model_free() > 0);
                if (exp_grant) begin
                    s = 0;
                    while (model_occ[s]) s++;
                    model_occ[s] = 1'b1;
                    last_spot = s;
                end
                chk("entry_ack", 32'(entry_ack), exp_grant ? 1 : 0);
                chk("entry_nak", 32'(entry_nak), exp_grant ? 0 : 1);
                chk("entry_spot", 32'(entry_spot), last_spot);
                chk("exit_pulses_on_entry", 32'({exit_ack, exit_err}), 0);
                $display("txn entry ack=%0b nak=%0b spot=%0d occ=%b free=%0d",
                         entry_ack, entry_nak, entry_spot, occ_map, free_cnt);
                entry_req = 1'b0;
            end
            check_lot("resp");
            chk("gate_closed_at_resp", 32'(gate_open), 0);
            step();
            chk("pulses_cleared", 32'({entry_ack, entry_nak, exit_ack, exit_err}), 0);
            chk("gate_after_resp", 32'(gate_open), exp_grant ? 1 : 0);
            if (exp_grant) begin
                glen = 0;
                while (gate_open && glen < G + 4) begin
                    glen++;
                    step();
                end
                chk("gate_len", glen, G);
            end
            check_lot("post");
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst.occ_map", 32'(occ_map), 0);
        chk("rst.free_cnt", 32'(free_cnt), N);
        chk("rst.full", 32'(full), 0);
        chk("rst.gate_open", 32'(gate_open), 0);
        chk("rst.pulses", 32'({entry_ack, entry_nak, exit_ack, exit_err}), 0);
        chk("rst.entry_spot", 32'(entry_spot), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) run_txn(1'b1, 1'b0, 2'd0);
        run_txn(1'b1, 1'b0, 2'd0);
        run_txn(1'b0, 1'b1, 2'd2);
        run_txn(1'b1, 1'b0, 2'd0);
        chk("reuse_spot2", 32'(entry_spot), 2);

        run_txn(1'b0, 1'b1, 2'd1);
        run_txn(1'b0, 1'b1, 2'd2);
        run_txn(1'b0, 1'b1, 2'd3);
        run_txn(1'b0, 1'b1, 2'd3);

        for (int i = 0; i < 3; i++) run_txn(1'b1, 1'b0, 2'd0);
        run_txn(1'b1, 1'b1, 2'd0);
        chk("pair_final_occ", 32'(occ_map), 32'hF);

        // Reset asserted in the third cycle of an open gate
        pulse_reset();
        run_txn(1'b1, 1'b0, 2'd0);
        run_txn(1'b1, 1'b0, 2'd0);
        entry_req = 1'b1;
        step();
        chk("mid.entry_ack", 32'(entry_ack), 1);
        entry_req = 1'b0;
        step();
        step();
        step();
        chk("mid.gate_open_before", 32'(gate_open), 1);
        chk("mid.occ_before", 32'(occ_map), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.gate_open", 32'(gate_open), 0);
        chk("mid.occ_map", 32'(occ_map), 0);
        chk("mid.free_cnt", 32'(free_cnt), N);
        chk("mid.pulses", 32'({entry_ack, entry_nak, exit_ack, exit_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_txn(1'b1, 1'b0, 2'd0);

        for (int t = 0; t < 60; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      run_txn(1'b1, 1'b0, 2'd0);
            else if (r < 8) run_txn(1'b0, 1'b1, 2'($urandom_range(0, 3)));
            else            run_txn(1'b1, 1'b1, 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
